// File: rtl/m_pkg.sv
`timescale 1ns/1ps
// Shared types for the m packet path.
package m_pkg;

  localparam int unsigned M_DATA_FIFO_N = 64;
  localparam int unsigned M_LEN_FIFO_N  = 4;
  localparam int unsigned DATA_W        = 8;
  // Lengths run 1..M_DATA_FIFO_N inclusive, so one bit more than the index.
  localparam int unsigned LEN_W         = $clog2(M_DATA_FIFO_N) + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0]  len_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // One framed egress beat as held in the output register.
  typedef struct packed {
    logic  vld;
    logic  sop;
    logic  eop;
    len_t  len;
    data_t data;
  } tx_beat_t;

endpackage

// File: rtl/m_fifo.sv
`timescale 1ns/1ps
// Synchronous FIFO, show-ahead read, registered full/empty flags.
//  push/din      write side (ignored when full)
//  pop           read side (ignored when empty)
//  dout_c        head entry
//  peek_c        entry behind the head; valid when two_c
//  two_c         at least two entries stored
//  full_r/empty_r registered level flags
//  full_nxt_c    full flag as it will be after this edge
module m_fifo #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout_c,
  output logic [W-1:0] peek_c,
  output logic         two_c,
  output logic         full_r,
  output logic         empty_r,
  output logic         full_nxt_c
);

  localparam int unsigned AW = $clog2(N);

  logic [W-1:0]  mem [N];
  logic [AW:0]   wr_q, rd_q, wr_d, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] rd_idx, rd_idx1;
  logic          do_push, do_pop;

  assign do_push = push & ~full_r;
  assign do_pop  = pop & ~empty_r;

  // Pointers carry one extra MSB so full and empty stay distinct.
  assign wr_d  = wr_q + (AW+1)'(do_push);
  assign rd_d  = rd_q + (AW+1)'(do_pop);
  assign cnt_q = wr_q - rd_q;
  assign cnt_d = wr_d - rd_d;

  assign full_nxt_c = (cnt_d == (AW+1)'(N));
  assign two_c      = (cnt_q >= (AW+1)'(2));

  assign rd_idx  = rd_q[AW-1:0];
  assign rd_idx1 = rd_idx + AW'(1);
  assign dout_c  = mem[rd_idx];
  assign peek_c  = mem[rd_idx1];

  // Pointer and flag state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_r  <= full_nxt_c;
      empty_r <= (cnt_d == '0);
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/m_pkt_tx.sv
`timescale 1ns/1ps
// Store-and-forward packet transmitter feeding the m ingress stream.
//  clk, rst                     clock, async active-high reset
//  host_vld_w/last_w/data_w     host beat in; host_rdy_r accepts it
//  net_rdy_w                    downstream takes the current out beat
//  out_vld/sop/eop/length/data  framed beat out, held while net_rdy_w=0
//  err_trunc_r                  pulse when a packet hits the length limit
module m_pkt_tx
  import m_pkg::*;
#(
  parameter int unsigned DATA_FIFO_N = M_DATA_FIFO_N,
  parameter int unsigned LEN_FIFO_N  = M_LEN_FIFO_N
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  host_vld_w,
  input  logic  host_last_w,
  input  data_t host_data_w,
  output logic  host_rdy_r,
  input  logic  net_rdy_w,
  output logic  out_vld_r,
  output logic  out_sop_r,
  output logic  out_eop_r,
  output len_t  out_length_r,
  output data_t out_data_r,
  output logic  err_trunc_r
);

  tx_state_t state_q, state_d;
  tx_beat_t  out_q, out_d;
  len_t      rem_q, rem_d;
  len_t      beat_cnt_q, beat_nxt_c;
  logic      accept_c, lim_c, len_push_c;

  data_t     d_dout_c, d_peek_c;
  logic      d_two_c, d_full_r, d_empty_r, d_full_nxt_c, d_pop_c;
  len_t      l_dout_c, l_peek_c;
  logic      l_two_c, l_full_r, l_empty_r, l_full_nxt_c, l_pop_c;
  logic      unused_c;

  // Ingress: count beats, close a packet on last or at the depth limit.
  assign accept_c   = host_vld_w & host_rdy_r;
  assign beat_nxt_c = beat_cnt_q + len_t'(1);
  assign lim_c      = (beat_nxt_c == len_t'(DATA_FIFO_N));
  assign len_push_c = accept_c & (host_last_w | lim_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      err_trunc_r <= 1'b0;
      host_rdy_r  <= 1'b0;
    end else begin
      if (len_push_c)    beat_cnt_q <= '0;
      else if (accept_c) beat_cnt_q <= beat_nxt_c;
      err_trunc_r <= accept_c & ~host_last_w & lim_c;
      host_rdy_r  <= ~(d_full_nxt_c | l_full_nxt_c);
    end
  end

  m_fifo #(.W($bits(data_t)), .N(DATA_FIFO_N)) u_data_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_c),
    .din        (host_data_w),
    .pop        (d_pop_c),
    .dout_c     (d_dout_c),
    .peek_c     (d_peek_c),
    .two_c      (d_two_c),
    .full_r     (d_full_r),
    .empty_r    (d_empty_r),
    .full_nxt_c (d_full_nxt_c)
  );

  m_fifo #(.W($bits(len_t)), .N(LEN_FIFO_N)) u_len_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (len_push_c),
    .din        (beat_nxt_c),
    .pop        (l_pop_c),
    .dout_c     (l_dout_c),
    .peek_c     (l_peek_c),
    .two_c      (l_two_c),
    .full_r     (l_full_r),
    .empty_r    (l_empty_r),
    .full_nxt_c (l_full_nxt_c)
  );

  // Data FIFO level/peek outputs are not needed on this path.
  assign unused_c = ^{d_peek_c, d_two_c, d_full_r, d_empty_r, l_full_r};

  // Egress FSM. The head data beat moves into the output register as soon
  // as it is presented, so the data FIFO pops on load; the length entry
  // stays queued until its eop beat is taken.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rem_d   = rem_q;
    d_pop_c = 1'b0;
    l_pop_c = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!l_empty_r) begin
          state_d    = TX_SEND;
          out_d.vld  = 1'b1;
          out_d.sop  = 1'b1;
          out_d.eop  = (l_dout_c == len_t'(1));
          out_d.len  = l_dout_c;
          out_d.data = d_dout_c;
          rem_d      = l_dout_c;
          d_pop_c    = 1'b1;
        end
      end
      TX_SEND: begin
        if (net_rdy_w) begin
          if (out_q.eop) begin
            l_pop_c = 1'b1;
            // Chain straight into the next queued packet: no bubble.
            if (l_two_c) begin
              out_d.sop  = 1'b1;
              out_d.eop  = (l_peek_c == len_t'(1));
              out_d.len  = l_peek_c;
              out_d.data = d_dout_c;
              rem_d      = l_peek_c;
              d_pop_c    = 1'b1;
            end else begin
              state_d   = TX_IDLE;
              out_d.vld = 1'b0;
              out_d.sop = 1'b0;
              out_d.eop = 1'b0;
            end
          end else begin
            out_d.sop  = 1'b0;
            out_d.eop  = (rem_q == len_t'(2));
            out_d.data = d_dout_c;
            rem_d      = rem_q - len_t'(1);
            d_pop_c    = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // FSM state and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      out_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
    end
  end

  assign out_vld_r    = out_q.vld;
  assign out_sop_r    = out_q.sop;
  assign out_eop_r    = out_q.eop;
  assign out_length_r = out_q.len;
  assign out_data_r   = out_q.data;

endmodule

// File: tb/tb_m_pkt_tx.sv
`timescale 1ns/1ps
module tb_m_pkt_tx;
  import m_pkg::*;

  localparam int unsigned DN = 64;
  localparam int unsigned LN = 4;

  typedef struct {
    logic  sop;
    logic  eop;
    len_t  len;
    data_t data;
  } exp_beat_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  host_vld_w, host_last_w, host_rdy_r, net_rdy_w;
  data_t host_data_w;
  logic  out_vld_r, out_sop_r, out_eop_r, err_trunc_r;
  len_t  out_length_r;
  data_t out_data_r;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_trunc = 0;
  bit trunc_exp = 1'b0;
  bit rnd_rdy = 1'b0;
  exp_beat_t exp_q[$];
  data_t     cur[$];
  int        take_cyc[$];

  always #5 clk = ~clk;

  m_pkt_tx #(.DATA_FIFO_N(DN), .LEN_FIFO_N(LN)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_vld_w   (host_vld_w),
    .host_last_w  (host_last_w),
    .host_data_w  (host_data_w),
    .host_rdy_r   (host_rdy_r),
    .net_rdy_w    (net_rdy_w),
    .out_vld_r    (out_vld_r),
    .out_sop_r    (out_sop_r),
    .out_eop_r    (out_eop_r),
    .out_length_r (out_length_r),
    .out_data_r   (out_data_r),
    .err_trunc_r  (err_trunc_r)
  );

  // Reference model: packets are collected from accepted host beats and
  // expanded into the framed beat list the output must follow.
  always @(negedge clk) begin
    exp_beat_t e;
    cyc++;
    if (rst) begin
      exp_q.delete();
      cur.delete();
      trunc_exp = 1'b0;
    end else begin
      n_vec++;
      assert (err_trunc_r === trunc_exp) else begin
        n_err++;
        $error("FAIL err_trunc: got %b expected %b", err_trunc_r, trunc_exp);
      end
      if (err_trunc_r === 1'b1) n_trunc++;
      trunc_exp = 1'b0;
      if (out_vld_r === 1'b1) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL spurious_beat: got beat data %h expected none", out_data_r);
        end
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          n_vec++;
          assert ({out_sop_r, out_eop_r, out_length_r, out_data_r} ===
                  {e.sop, e.eop, e.len, e.data}) else begin
            n_err++;
            $error("FAIL out_beat: got sop%b eop%b len%0d data%h expected sop%b eop%b len%0d data%h",
                   out_sop_r, out_eop_r, out_length_r, out_data_r, e.sop, e.eop, e.len, e.data);
          end
          if (net_rdy_w) begin
            void'(exp_q.pop_front());
            take_cyc.push_back(cyc);
          end
        end
      end
      if (host_vld_w && host_rdy_r) begin
        cur.push_back(host_data_w);
        if (host_last_w || cur.size() == DN) begin
          if (!host_last_w) trunc_exp = 1'b1;
          foreach (cur[i])
            exp_q.push_back('{i == 0, i == cur.size() - 1, len_t'(cur.size()), cur[i]});
          cur.delete();
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_vec++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) net_rdy_w = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input data_t d, input logic last);
    bit ok;
    ok = 1'b0;
    host_vld_w  = 1'b1;
    host_data_w = d;
    host_last_w = last;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      ok = host_rdy_r;
      step();
    end
    host_vld_w  = 1'b0;
    host_last_w = 1'b0;
    chk("host_accept_timeout", 64'(ok), 64'(1));
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    net_rdy_w = 1'b1;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && (cur.size() == 0) && (out_vld_r === 1'b0);
    end
    @(posedge clk);
    #1;
    chk("drain_timeout", 64'(ok), 64'(1));
  endtask

  initial begin
    int t0, len, a, b;
    bit seen;
    rst = 1'b1;
    host_vld_w = 1'b0;
    host_last_w = 1'b0;
    host_data_w = '0;
    net_rdy_w = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r,
                              err_trunc_r, host_rdy_r}), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_reset", 64'(host_rdy_r), 64'(1));

    // 1: single-beat packet, latency two cycles from acceptance
    net_rdy_w = 1'b1;
    send_beat(8'hA5, 1'b1);
    @(negedge clk);
    chk("t1_not_yet", 64'(out_vld_r), 64'(0));
    @(negedge clk);
    chk("t1_beat", 64'({out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r}),
        64'({1'b1, 1'b1, 1'b1, len_t'(1), 8'hA5}));
    drain();

    // 2: 4-beat then 2-beat packet, emitted back to back
    for (int i = 1; i <= 4; i++) send_beat(data_t'(i), i == 4);
    send_beat(8'd5, 1'b0);
    send_beat(8'd6, 1'b1);
    drain();
    a = take_cyc[take_cyc.size() - 1];
    b = take_cyc[take_cyc.size() - 6];
    chk("t2_contiguous", 64'(a - b), 64'(5));

    // 3: backpressure mid-packet
    for (int i = 0; i < 6; i++) send_beat(data_t'(8'h30 + i), i == 5);
    idle(3);
    net_rdy_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_held_mid", 64'({out_vld_r, out_sop_r}), 64'({1'b1, 1'b0}));
      @(posedge clk);
      #1;
    end
    drain();

    // 4: 65-beat packet splits into 64 + 1 with a truncation pulse
    t0 = n_trunc;
    for (int i = 1; i <= 65; i++) send_beat(data_t'(i), i == 65);
    drain();
    chk("t4_trunc_count", 64'(n_trunc - t0), 64'(1));

    // 5: length FIFO fills with 4 packets while downstream stalls
    net_rdy_w = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(data_t'(8'h50 + i), 1'b1);
    @(negedge clk);
    chk("t5_rdy_low", 64'(host_rdy_r), 64'(0));
    idle(2);
    @(negedge clk);
    chk("t5_rdy_still_low", 64'(host_rdy_r), 64'(0));
    @(posedge clk);
    #1;
    net_rdy_w = 1'b1;
    send_beat(8'h54, 1'b1);
    drain();

    // 6: reset while a 3-beat packet is being sent
    net_rdy_w = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(data_t'(8'h70 + i), i == 2);
    idle(3);
    @(negedge clk);
    chk("t6_sending", 64'(out_vld_r), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_reset_outputs", 64'({out_vld_r, out_sop_r, out_eop_r, out_length_r, out_data_r,
                                 err_trunc_r, host_rdy_r}), 64'(0));
    idle(2);
    rst = 1'b0;
    net_rdy_w = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(negedge clk);
      seen = out_vld_r;
    end
    chk("t6_restart", 64'({seen, out_sop_r, out_length_r, out_data_r}),
        64'({1'b1, 1'b1, len_t'(2), 8'h11}));
    drain();

    // Randomized packets with random downstream stalls
    rnd_rdy = 1'b1;
    for (int p = 0; p < 30; p++) begin
      len = (p % 8 == 7) ? int'($urandom_range(60, 70)) : int'($urandom_range(1, 10));
      for (int i = 0; i < len; i++) send_beat(data_t'($urandom), i == len - 1);
      idle(int'($urandom_range(0, 2)));
    end
    rnd_rdy = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
